// File: rtl/delta_adc_mc.sv
// Multi-channel PWM-feedback delta ADC: shared period/strobe counters, per-channel tracking
// loops and a round-robin result stream. Define DELTA_ADC_MC_AVG_EN to report 4-tick averages.
module delta_adc_mc #(
  parameter int unsigned W             = 16,
  parameter int unsigned CH            = 4,
  parameter int unsigned STROBE_CYCLES = 64,
  parameter int unsigned STEP          = 1,
  localparam int unsigned CW           = (CH > 1) ? $clog2(CH) : 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          enable_i,
  input  logic [W-1:0]  period_i,
  input  logic [CH-1:0] comparator_i,
  output logic [CH-1:0] pwm_o,
  output logic [W-1:0]  result_data_o,
  output logic [CW-1:0] result_ch_o,
  output logic          result_valid_o,
  input  logic          result_ready_i,
  output logic [CH-1:0] overrun_o,
  input  logic          overrun_clr_i
);

  localparam int unsigned SW = $clog2(STROBE_CYCLES);

  logic [CH-1:0] sync1_q, sync2_q;
  logic [W-1:0]  cnt_q, shadow_q;
  logic [SW-1:0] strobe_q;
  logic [W-1:0]  duty_q [CH];
  logic [W-1:0]  duty_d [CH];
  logic [W-1:0]  res_q  [CH];
  logic [W-1:0]  res_d  [CH];
  logic [CH-1:0] pend_q, pend_d, pop, ovr_q, ovr_d, pwm_q, pwm_d;
  logic [W-1:0]  data_q;
  logic [CW-1:0] ch_q, ptr_q, sel, idx;
  logic          valid_q, found, pop_en, wrap, load, tick, report;

  // A shadow of 0/1 counts as a permanent wrap, so the first enabled cycle loads period_i.
  assign wrap = (shadow_q < W'(2)) || (cnt_q == shadow_q - W'(1));
  assign load = enable_i && wrap;
  assign tick = enable_i && (strobe_q == SW'(STROBE_CYCLES - 1));

`ifdef DELTA_ADC_MC_AVG_EN
  logic [1:0]   avg_q;
  logic [W+1:0] acc_q [CH];
  logic [W+1:0] acc_d [CH];
  assign report = tick && (avg_q == 2'd3);
`else
  assign report = tick;
`endif

  for (genvar c = 0; c < CH; c++) begin : gen_ch
    logic [W:0] up, nxt;
    always_comb begin
      up  = {1'b0, duty_q[c]} + (W+1)'(STEP);
      nxt = {1'b0, duty_q[c]};
      if (tick) begin
        if (sync2_q[c]) begin
          nxt = (up > {1'b0, shadow_q}) ? {1'b0, shadow_q} : up;
        end else begin
          nxt = (nxt >= (W+1)'(STEP)) ? nxt - (W+1)'(STEP) : '0;
        end
      end
      // Clamp against the period that is being loaded on this same edge.
      if (load && (nxt > {1'b0, period_i})) nxt = {1'b0, period_i};
    end
    assign duty_d[c] = nxt[W-1:0];
`ifdef DELTA_ADC_MC_AVG_EN
    logic [W+1:0] sum;
    assign sum      = acc_q[c] + {2'b00, duty_d[c]};
    assign acc_d[c] = report ? '0 : (tick ? sum : acc_q[c]);
    assign res_d[c] = report ? sum[W+1:2] : res_q[c];
`else
    assign res_d[c] = report ? duty_d[c] : res_q[c];
`endif
  end

  always_comb begin
    found = 1'b0;
    sel   = '0;
    idx   = '0;
    for (int i = 0; i < CH; i++) begin
      idx = CW'((int'(ptr_q) + i) % CH);
      if (!found && pend_q[idx]) begin
        found = 1'b1;
        sel   = idx;
      end
    end
    pop_en = !valid_q || result_ready_i;
    pop    = (pop_en && found) ? (CH'(1) << sel) : '0;
    // A tick re-arms a channel even if it is popped on the same edge.
    pend_d = (pend_q & ~pop) | {CH{report}};
    ovr_d  = (overrun_clr_i ? '0 : ovr_q) | ({CH{report}} & pend_q & ~pop);
    for (int c = 0; c < CH; c++) begin
      pwm_d[c] = enable_i && (shadow_q >= W'(2)) && (cnt_q < duty_q[c]);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1_q  <= '0;
      sync2_q  <= '0;
      cnt_q    <= '0;
      shadow_q <= '0;
      strobe_q <= '0;
      pend_q   <= '0;
      ovr_q    <= '0;
      pwm_q    <= '0;
      data_q   <= '0;
      ch_q     <= '0;
      ptr_q    <= '0;
      valid_q  <= 1'b0;
      for (int c = 0; c < CH; c++) begin
        duty_q[c] <= '0;
        res_q[c]  <= '0;
      end
    end else begin
      sync1_q <= comparator_i;
      sync2_q <= sync1_q;
      if (enable_i) begin
        cnt_q    <= load ? '0 : cnt_q + W'(1);
        strobe_q <= tick ? '0 : strobe_q + SW'(1);
        if (load) shadow_q <= period_i;
      end
      for (int c = 0; c < CH; c++) begin
        duty_q[c] <= duty_d[c];
        res_q[c]  <= res_d[c];
      end
      pend_q <= pend_d;
      ovr_q  <= ovr_d;
      pwm_q  <= pwm_d;
      if (pop_en) begin
        if (found) begin
          valid_q <= 1'b1;
          data_q  <= res_q[sel];
          ch_q    <= sel;
          ptr_q   <= (sel == CW'(CH - 1)) ? '0 : sel + CW'(1);
        end else begin
          valid_q <= 1'b0;
        end
      end
    end
  end

`ifdef DELTA_ADC_MC_AVG_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      avg_q <= '0;
      for (int c = 0; c < CH; c++) acc_q[c] <= '0;
    end else begin
      if (tick) avg_q <= avg_q + 2'd1;
      for (int c = 0; c < CH; c++) acc_q[c] <= acc_d[c];
    end
  end
`endif

  assign pwm_o          = pwm_q;
  assign result_data_o  = data_q;
  assign result_ch_o    = ch_q;
  assign result_valid_o = valid_q;
  assign overrun_o      = ovr_q;

endmodule
